// File: rtl/netarbiter.sv
// Packet-level round-robin arbiter: merges NIN abortable AXIN streams onto one
// registered output stream, holding each grant from first beat to LAST or ABORT.
module netarbiter #(
    parameter int unsigned NIN = 4,
    parameter int unsigned DW  = 32
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic [NIN-1:0]    S_AXIN_VALID,
    output logic [NIN-1:0]    S_AXIN_READY,
    input  logic [NIN*DW-1:0] S_AXIN_DATA,
    input  logic [NIN-1:0]    S_AXIN_LAST,
    input  logic [NIN-1:0]    S_AXIN_ABORT,
    output logic              M_AXIN_VALID,
    input  logic              M_AXIN_READY,
    output logic [DW-1:0]     M_AXIN_DATA,
    output logic              M_AXIN_LAST,
    output logic              M_AXIN_ABORT,
    output logic [NIN-1:0]    o_grant
);

    localparam int unsigned IW = (NIN > 1) ? $clog2(NIN) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } state_t;

    state_t         state;
    logic [IW-1:0]  gidx;
    logic [IW-1:0]  rr;
    logic           started;

    logic [NIN-1:0] eligible;
    logic [IW-1:0]  win_idx;
    logic [IW-1:0]  cand;
    logic           win_found;
    logic           ofree;
    logic           can_grant;
    logic           g_valid;
    logic           g_last;
    logic           g_abort;
    logic [DW-1:0]  g_data;
    logic           accept;

    assign ofree     = !M_AXIN_VALID || M_AXIN_READY;
    assign can_grant = !(M_AXIN_ABORT && !M_AXIN_READY);
    assign eligible  = S_AXIN_VALID & ~S_AXIN_ABORT;
    assign g_valid   = S_AXIN_VALID[gidx];
    assign g_last    = S_AXIN_LAST[gidx];
    assign g_abort   = S_AXIN_ABORT[gidx];
    assign g_data    = S_AXIN_DATA[32'(gidx)*DW +: DW];
    assign accept    = (state == ST_PKT) && !g_abort && g_valid && ofree && !M_AXIN_ABORT;

    // First eligible requester searching upward from the one after the last winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NIN; i++) begin
            cand = IW'((32'(rr) + i) % NIN);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // An abort from the granted source is acknowledged even while the output is stalled
    always_comb begin
        S_AXIN_READY = '0;
        if (state == ST_PKT) begin
            S_AXIN_READY[gidx] = g_abort || (ofree && !M_AXIN_ABORT);
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state        <= ST_IDLE;
            gidx         <= '0;
            rr           <= IW'(NIN - 1);
            started      <= 1'b0;
            o_grant      <= '0;
            M_AXIN_VALID <= 1'b0;
            M_AXIN_DATA  <= '0;
            M_AXIN_LAST  <= 1'b0;
            M_AXIN_ABORT <= 1'b0;
        end else begin
            if (M_AXIN_READY) begin
                M_AXIN_VALID <= 1'b0;
                M_AXIN_ABORT <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (can_grant && win_found) begin
                        state   <= ST_PKT;
                        gidx    <= win_idx;
                        rr      <= win_idx;
                        started <= 1'b0;
                        o_grant <= NIN'(1) << win_idx;
                    end
                end
                ST_PKT: begin
                    if (g_abort) begin
                        // A partially forwarded packet is killed and its pending word dropped
                        if (started) begin
                            M_AXIN_ABORT <= 1'b1;
                            M_AXIN_VALID <= 1'b0;
                            M_AXIN_LAST  <= 1'b0;
                        end
                        state   <= ST_IDLE;
                        started <= 1'b0;
                        o_grant <= '0;
                    end else if (accept) begin
                        M_AXIN_VALID <= 1'b1;
                        M_AXIN_DATA  <= g_data;
                        M_AXIN_LAST  <= g_last;
                        started      <= 1'b1;
                        if (g_last) begin
                            state   <= ST_IDLE;
                            started <= 1'b0;
                            o_grant <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_netarbiter.sv
// Self-checking bench for netarbiter: packet-level reference model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_netarbiter;

    localparam int NIN = 4;
    localparam int DW  = 32;

    typedef struct packed {
        int len;
        int base;
        int abort_at;
    } pkt_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NIN-1:0]    s_valid = '0;
    logic [NIN-1:0]    s_last  = '0;
    logic [NIN-1:0]    src_abort = '0;
    logic [NIN-1:0]    extra_abort = '0;
    logic [NIN-1:0]    s_abort;
    logic [NIN-1:0]    s_ready;
    logic [NIN*DW-1:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic              m_abort;
    logic [NIN-1:0]    grant;

    always #5 clk = ~clk;
    assign s_abort = src_abort | extra_abort;

    netarbiter #(.NIN(NIN), .DW(DW)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXIN_VALID (s_valid),
        .S_AXIN_READY (s_ready),
        .S_AXIN_DATA  (s_data),
        .S_AXIN_LAST  (s_last),
        .S_AXIN_ABORT (s_abort),
        .M_AXIN_VALID (m_valid),
        .M_AXIN_READY (m_ready),
        .M_AXIN_DATA  (m_data),
        .M_AXIN_LAST  (m_last),
        .M_AXIN_ABORT (m_abort),
        .o_grant      (grant)
    );

    pkt_t srcq [NIN][$];
    int   beat [NIN];

    // Reference model: who owns the output, and what the output register must hold
    int             mo_owner = -1;
    bit             mo_started;
    int             mo_rr;
    bit             e_valid, e_last, e_abort;
    logic [DW-1:0]  e_data;
    logic [NIN-1:0] hs = '0;
    bit             chk_en = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [DW-1:0] got [$];
    int   got_t [$];
    logic [NIN-1:0] gseq [$];
    logic [NIN-1:0] prev_grant = '0;
    int abort_cnt, ready2_cnt, grant_cycles;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NIN-1:0] exp_ready();
        logic [NIN-1:0] r;
        r = '0;
        if (mo_owner >= 0)
            r[mo_owner] = s_abort[mo_owner] ? 1'b1 : ((!e_valid || m_ready) && !e_abort);
        return r;
    endfunction

    function automatic logic [NIN-1:0] exp_grant();
        logic [NIN-1:0] g;
        g = '0;
        if (mo_owner >= 0) g[mo_owner] = 1'b1;
        return g;
    endfunction

    always @(posedge clk) begin : model
        logic [NIN-1:0] r;
        int c;
        int g;
        bit nv, na, nl;
        logic [DW-1:0] nd;
        r = exp_ready();
        if (!rst_n) begin
            mo_owner = -1; mo_started = 0; mo_rr = NIN - 1;
            e_valid = 0; e_abort = 0; e_last = 0; hs = '0;
        end else begin
            hs = r & (s_valid | s_abort);
            nv = e_valid; na = e_abort; nl = e_last; nd = e_data;
            if (m_ready) begin nv = 0; na = 0; end
            if (mo_owner < 0) begin
                if (!(e_abort && !m_ready)) begin
                    for (int k = 1; k <= NIN; k++) begin
                        c = (mo_rr + k) % NIN;
                        if (mo_owner < 0 && s_valid[c] && !s_abort[c]) begin
                            mo_owner = c; mo_rr = c; mo_started = 0;
                        end
                    end
                end
            end else begin
                g = mo_owner;
                if (s_abort[g]) begin
                    if (mo_started) begin na = 1; nv = 0; end
                    mo_owner = -1; mo_started = 0;
                end else if (s_valid[g] && r[g]) begin
                    nv = 1; nd = s_data[g*DW +: DW]; nl = s_last[g]; mo_started = 1;
                    if (s_last[g]) begin mo_owner = -1; mo_started = 0; end
                end
            end
            e_valid = nv; e_abort = na; e_last = nl; e_data = nd;
        end
    end

    // Packet sources: advance on the model's handshake, then drive the next beat
    always @(posedge clk) begin : sources
        pkt_t p;
        #1;
        for (int n = 0; n < NIN; n++) begin
            if (!rst_n) begin
                beat[n] = 0;
            end else if (hs[n] && srcq[n].size() > 0) begin
                p = srcq[n][0];
                if (src_abort[n]) begin
                    void'(srcq[n].pop_front()); beat[n] = 0;
                end else begin
                    beat[n]++;
                    if (beat[n] == p.len) begin void'(srcq[n].pop_front()); beat[n] = 0; end
                end
            end
            if (srcq[n].size() > 0) begin
                p = srcq[n][0];
                s_valid[n] = 1'b1;
                s_data[n*DW +: DW] = DW'(p.base + beat[n]);
                s_last[n] = (beat[n] == p.len - 1);
                src_abort[n] = (p.abort_at == beat[n]) && (mo_owner == n);
            end else begin
                s_valid[n] = 1'b0; s_last[n] = 1'b0; src_abort[n] = 1'b0;
                s_data[n*DW +: DW] = '0;
            end
        end
    end

    // Per-cycle comparison against the model, plus output-side recording
    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", 64'(grant), 64'(exp_grant()));
            check("s_ready", 64'(s_ready), 64'(exp_ready()));
            check("m_valid", 64'(m_valid), 64'(e_valid));
            check("m_abort", 64'(m_abort), 64'(e_abort));
            if (e_valid) begin
                check("m_data", 64'(m_data), 64'(e_data));
                check("m_last", 64'(m_last), 64'(e_last));
            end
            if (m_valid && m_ready) begin got.push_back(m_data); got_t.push_back(cyc); end
            if (m_abort && m_ready) abort_cnt++;
            if (s_ready[2]) ready2_cnt++;
            if (grant != '0 && grant != prev_grant) gseq.push_back(grant);
            if (grant != '0) grant_cycles++;
            prev_grant = grant;
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
    endtask

    task automatic clear_rec();
        got.delete(); got_t.delete(); gseq.delete();
        abort_cnt = 0; ready2_cnt = 0; grant_cycles = 0;
    endtask

    task automatic push(input int n, input int len, input int base, input int abort_at);
        pkt_t p;
        p.len = len; p.base = base; p.abort_at = abort_at;
        srcq[n].push_back(p);
    endtask

    task automatic wait_drain(input string name);
        int k;
        bit busy;
        k = 0;
        busy = 1'b1;
        while (busy && k < 300) begin
            busy = (mo_owner >= 0) || e_valid || e_abort;
            for (int n = 0; n < NIN; n++) if (srcq[n].size() > 0) busy = 1'b1;
            if (busy) begin tick(1); k++; end
        end
        check({name, "_drain_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_beat(input int n, input int b, input string name);
        int k;
        k = 0;
        while (beat[n] != b && k < 100) begin tick(1); k++; end
        check({name, "_beat_timeout"}, 64'(beat[n]), 64'(b));
    endtask

    task automatic wait_owner(input int n, input string name);
        int k;
        k = 0;
        while (mo_owner != n && k < 100) begin tick(1); k++; end
        check({name, "_owner_timeout"}, 64'(mo_owner), 64'(n));
    endtask

    task automatic check_got(input string name, input logic [DW-1:0] exp [$]);
        check({name, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check({name, "_word"}, 64'(got[i]), 64'(exp[i]));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] exp [$];
        tick(2);
        chk_en = 1'b1;
        rst_n = 1'b1;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_abort", 64'(m_abort), 64'(0));
        check("rst_m_last",  64'(m_last),  64'(0));
        check("rst_grant",   64'(grant),   64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(0));

        // Inputs 0 and 2 each send a 3-word packet
        clear_rec();
        push(0, 3, 32'hA000_0000, -1);
        push(2, 3, 32'hA200_0000, -1);
        wait_drain("t1");
        exp = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                32'hA200_0000, 32'hA200_0001, 32'hA200_0002};
        check_got("t1", exp);
        check("t1_gseq_n", 64'(gseq.size()), 64'(2));
        if (gseq.size() == 2) begin
            check("t1_grant0", 64'(gseq[0]), 64'(4'b0001));
            check("t1_grant1", 64'(gseq[1]), 64'(4'b0100));
        end
        if (got_t.size() == 6) check("t1_bubble", 64'(got_t[3] - got_t[2]), 64'(2));

        // All four inputs send back-to-back single-word packets
        do_reset();
        clear_rec();
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < NIN; n++) push(n, 1, 32'hB000_0000 | (n << 16) | k, -1);
        wait_drain("t2");
        check("t2_gseq_n", 64'(gseq.size()), 64'(8));
        for (int i = 0; i < gseq.size() && i < 8; i++)
            check("t2_rotate", 64'(gseq[i]), 64'(4'b0001 << (i % 4)));
        check("t2_grant_cycles", 64'(grant_cycles), 64'(8));
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(32'hB000_0000 | ((i % 4) << 16) | (i / 4));
        check_got("t2", exp);

        // Five-word packet on input 1 with downstream READY toggling
        do_reset();
        clear_rec();
        push(1, 5, 32'hC100_0000, -1);
        for (int i = 0; i < 14; i++) begin m_ready = ~m_ready; tick(1); end
        m_ready = 1'b1;
        wait_drain("t3");
        exp.delete();
        for (int i = 0; i < 5; i++) exp.push_back(32'hC100_0000 + i);
        check_got("t3", exp);

        // Input 3 aborts after two beats while the output is stalled
        do_reset();
        clear_rec();
        push(3, 4, 32'hD300_0000, 2);
        wait_beat(3, 2, "t4");
        m_ready = 1'b0;
        push(0, 2, 32'hD000_0000, -1);
        tick(3);
        check("t4_abort_held", 64'(m_abort), 64'(1));
        check("t4_valid_low",  64'(m_valid), 64'(0));
        check("t4_no_grant",   64'(grant),   64'(0));
        m_ready = 1'b1;
        tick(1);
        check("t4_abort_done", 64'(m_abort), 64'(0));
        check("t4_next_grant", 64'(grant),   64'(4'b0001));
        wait_drain("t4");
        exp = '{32'hD300_0000, 32'hD000_0000, 32'hD000_0001};
        check_got("t4", exp);
        check("t4_abort_cnt", 64'(abort_cnt), 64'(1));

        // Input 2 aborts in its grant cycle; stray abort on ungranted input 1
        do_reset();
        clear_rec();
        push(2, 3, 32'hE200_0000, 0);
        wait_owner(2, "t5a");
        push(0, 3, 32'hE000_0000, -1);
        wait_owner(0, "t5b");
        tick(1);
        extra_abort[1] = 1'b1;
        tick(1);
        extra_abort[1] = 1'b0;
        wait_drain("t5");
        exp = '{32'hE000_0000, 32'hE000_0001, 32'hE000_0002};
        check_got("t5", exp);
        check("t5_ready2_pulses", 64'(ready2_cnt), 64'(1));
        check("t5_abort_cnt", 64'(abort_cnt), 64'(0));
        check("t5_gseq_n", 64'(gseq.size()), 64'(2));
        if (gseq.size() == 2) begin
            check("t5_grant0", 64'(gseq[0]), 64'(4'b0100));
            check("t5_grant1", 64'(gseq[1]), 64'(4'b0001));
        end

        // Reset dropped for one cycle in the middle of input 2's packet
        do_reset();
        clear_rec();
        push(2, 6, 32'hF200_0000, -1);
        wait_beat(2, 3, "t6");
        push(0, 2, 32'hF000_0000, -1);
        push(3, 2, 32'hF300_0000, -1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_valid", 64'(m_valid), 64'(0));
        check("t6_abort", 64'(m_abort), 64'(0));
        check("t6_grant", 64'(grant),   64'(0));
        tick(1);
        check("t6_restart_grant", 64'(grant), 64'(4'b0001));
        wait_drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
